div_ctrl: RTL and testbench

//  Sequential controller for signed 32-bit division in the multdiv unit.

---
 rtl/div_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_div_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequential signed 32-bit divider controller for the multdiv unit.
// Restoring shift-subtract over a remainder/quotient pair; the quotient is
// truncated toward zero and presented with a one-cycle ready pulse.
// Optional build macro DIV_ALIGN_EN adds an aligner that skips leading
// iterations when both operand magnitudes fit in 31 bits.

`ifdef DIV_ALIGN_EN
// Aligns b's leading one with a's; reports the shift and whether b's leading
// one sits above a's (quotient necessarily zero).
module div_ctrl_aligner (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] d,
  output logic [5:0]  shftamt,
  output logic        b_above
);

  // Leading-zero count; 32 for an all-zero word.
  function automatic logic [5:0] lzc(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  logic [5:0] lza;
  logic [5:0] lzb;

  // Compare leading-one positions and shift the divisor into place.
  always_comb begin
    lza     = lzc(a);
    lzb     = lzc(b);
    b_above = (lzb < lza);
    shftamt = b_above ? '0 : (lzb - lza);
    d       = b << shftamt;
  end

endmodule
`endif

module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIX   = 2'd2,
    ALIGN = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             sa;
  logic             sb;
  logic             divz;
  logic [WIDTH-1:0] magb;
  // The remainder always stays below magb, so WIDTH bits hold it.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] op_maga;
  logic [WIDTH-1:0] op_magb;
  logic             op_bz;
  logic [WIDTH:0]   trial;
  logic             iter_last;
  logic             start_align;

`ifdef DIV_ALIGN_EN
  logic [WIDTH-1:0] maga;
  logic [WIDTH-1:0] dvs;
  logic             aln;
  logic [WIDTH-1:0] al_d;
  logic [5:0]       al_shft;
  logic             al_above;

  div_ctrl_aligner u_aligner (
    .a       (maga),
    .b       (magb),
    .d       (al_d),
    .shftamt (al_shft),
    .b_above (al_above)
  );
`endif

  // Operand magnitudes, trial subtraction and loop termination.
  always_comb begin
    op_maga = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    op_magb = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    op_bz   = (data_operandB == '0);
    trial   = {rem, quo[WIDTH-1]} - {1'b0, magb};
`ifdef DIV_ALIGN_EN
    start_align = !op_bz && !op_maga[WIDTH-1] && !op_magb[WIDTH-1];
    iter_last   = aln ? (cnt == '0) : (cnt == CNT_W'(WIDTH-1));
`else
    start_align = 1'b0;
    iter_last   = (cnt == CNT_W'(WIDTH-1));
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a start pulse overrides whatever is in progress.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    if (ctrl_DIV) begin
      if (op_bz)            state_nxt = FIX;
      else if (start_align) state_nxt = ALIGN;
      else                  state_nxt = ITER;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
`ifdef DIV_ALIGN_EN
        ALIGN:   state_nxt = al_above ? FIX : ITER;
`endif
        ITER:    state_nxt = iter_last ? FIX : ITER;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: operand latch, iteration, result sign fix and ready pulse.
  // The FIX update is placed after the start latch so a start arriving on the
  // FIX edge still delivers the finishing operation's exception flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sa             <= 1'b0;
      sb             <= 1'b0;
      divz           <= 1'b0;
      magb           <= '0;
      rem            <= '0;
      quo            <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_ALIGN_EN
      maga           <= '0;
      dvs            <= '0;
      aln            <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        sa             <= data_operandA[WIDTH-1];
        sb             <= data_operandB[WIDTH-1];
        divz           <= op_bz;
        magb           <= op_magb;
        rem            <= '0;
        quo            <= op_maga;
        cnt            <= '0;
        data_exception <= 1'b0;
`ifdef DIV_ALIGN_EN
        maga           <= op_maga;
        dvs            <= '0;
        aln            <= start_align;
`endif
      end else begin
        case (state)
`ifdef DIV_ALIGN_EN
          ALIGN: begin
            quo <= '0;
            if (!al_above) begin
              dvs <= al_d;
              cnt <= CNT_W'(al_shft);
              rem <= maga;
            end
          end
          ITER: begin
            if (aln) begin
              if (rem >= dvs) begin
                rem <= rem - dvs;
                quo <= {quo[WIDTH-2:0], 1'b1};
              end else begin
                quo <= {quo[WIDTH-2:0], 1'b0};
              end
              dvs <= dvs >> 1;
              cnt <= cnt - 1'b1;
            end else begin
              if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
              end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
              end
              cnt <= cnt + 1'b1;
            end
          end
`else
          ITER: begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
`endif
          default: ;
        endcase
      end
      if (state == FIX) begin
        data_resultRDY <= 1'b1;
        data_exception <= divz;
        if (divz)          data_result <= '0;
        else if (sa ^ sb)  data_result <= ~quo + 1'b1;
        else               data_result <= quo;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized scoreboard bench for div_ctrl. Expected quotient,
// exception and ready edge come from plain signed arithmetic; a monitor pops
// and compares on every ready pulse.
module tb_div_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (a),
    .data_operandB  (b),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic int msb(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: signed division truncated toward zero, low 32 bits kept.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int e);
    exp_t r;
    longint sx, sy, qv;
    logic [63:0] qb;
    int lat;
    if (y == 0) begin
      r.res = '0;
      r.exc = 1'b1;
      lat = 1;
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      qv = sx / sy;
      qb = qv;
      r.res = qb[31:0];
      r.exc = 1'b0;
      lat = 33;
`ifdef DIV_ALIGN_EN
      begin
        logic [31:0] mx, my;
        mx = x[31] ? 32'd0 - x : x;
        my = y[31] ? 32'd0 - y : y;
        if (!mx[31] && !my[31]) begin
          if (msb(my) > msb(mx)) lat = 2;
          else lat = msb(mx) - msb(my) + 3;
        end
      end
`endif
    end
    r.due = e + lat;
    return r;
  endfunction

  // Called at a negedge; the start is sampled at the following posedge.
  task automatic start(input logic [31:0] x, input logic [31:0] y);
    int e;
    e = cyc + 1;
    a = x;
    b = y;
    ctrl_DIV = 1'b1;
    while (q.size() > 0 && q[q.size()-1].due > e) void'(q.pop_back());
    q.push_back(model(x, y, e));
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%08h required=0x%08h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0: return $urandom;
      1: return $urandom_range(0, 1000);
      2: return 32'd0 - $urandom_range(1, 1000);
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  exp_t h;

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (resetn) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_ready due=%0d now=%0d", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (data_resultRDY) begin
        checks++;
        if (q.size() == 0 || q[0].due != cyc) begin
          failures++;
          $display("FAIL unexpected_ready cyc=%0d got_ready=1 required_ready=0", cyc);
        end else begin
          h = q.pop_front();
          chk("result", data_result, h.res);
          chk("exception", {31'd0, data_exception}, {31'd0, h.exc});
        end
      end
    end
  end

  initial begin
    int d;
    logic [31:0] x, y;
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exception", {31'd0, data_exception}, 32'd0);
    chk("rst_ready", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    start(32'd100, 32'd7);
    chk("busy_running", {31'd0, busy}, 32'd1);
    wait_drain(60);
    start(-32'sd100, 32'd7);           wait_drain(60);
    start(-32'sd100, -32'sd7);         wait_drain(60);
    start(32'd7, 32'd100);             wait_drain(60);
    start(32'd5, 32'd0);               wait_drain(60);
    start(32'd9, 32'd3);               wait_drain(60);
    start(32'h8000_0000, 32'hFFFF_FFFF); wait_drain(60);
    start(32'h7FFF_FFFF, 32'd1);       wait_drain(60);
    start(32'd0, 32'd5);               wait_drain(60);

    // Restart at edge 10 of a running operation.
    start(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    start(32'd50, 32'd5);
    wait_drain(60);

    // Start coinciding with the finishing ready pulse.
    start(32'd1000, 32'd33);
    d = q[0].due;
    while (cyc < d - 1) @(negedge clock);
    start(32'd9, 32'd3);
    wait_drain(60);

    // Reset at edge 15 aborts with no pulse.
    start(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    resetn = 1'b0;
    while (q.size() > 0 && q[q.size()-1].due >= cyc + 1) void'(q.pop_back());
    @(negedge clock);
    chk("abort_result", data_result, 32'd0);
    chk("abort_exception", {31'd0, data_exception}, 32'd0);
    chk("abort_ready", {31'd0, data_resultRDY}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    repeat (40) @(negedge clock);

    for (int n = 0; n < 200; n++) begin
      x = rnd_op();
      y = ($urandom % 8 == 0) ? 32'd0 : rnd_op();
      if ($urandom % 10 < 7) wait_drain(60);
      else repeat ($urandom_range(0, 39)) @(negedge clock);
      start(x, y);
    end
    wait_drain(60);
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
